// File: rtl/button_conditioner.sv
// Raw active-low push-button front end: two-flop synchronizer, shared ms timebase and a
// per-button debounce/auto-repeat FSM producing a debounced level and one-cycle press pulses.
`timescale 1ns/1ps
module button_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int TICK_CYCLES     = 50000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [NUM_BTN-1:0] Buttons_n,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] oLevel,
    output logic [NUM_BTN-1:0] oPulse
);

    localparam int              PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [9:0]      DB_LAST    = 10'(DEBOUNCE_MS - 1);
    localparam logic [9:0]      DELAY_LAST = 10'(REPEAT_DELAY_MS - 1);
    localparam logic [9:0]      RATE_LAST  = 10'(REPEAT_RATE_MS - 1);

    typedef enum logic [2:0] {IDLE, DB_DN, HELD, REPEAT, DB_UP} state_t;

    logic [NUM_BTN-1:0] sync1, sync2;
    logic [NUM_BTN-1:0] pressed;
    logic [PW-1:0]      presc;
    logic               tick;
    state_t             state [NUM_BTN];
    logic [9:0]         cnt   [NUM_BTN];

    // NOTE: synchronizer flops reset to 1 (released) so leaving reset never looks like a press.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= Buttons_n;
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            presc <= '0;
        end else if (presc == TICK_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            oLevel <= '0;
            oPulse <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                // NOTE: default-clear makes every pulse exactly one cycle wide.
                oPulse[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (pressed[i]) begin
                            state[i] <= DB_DN;
                            cnt[i]   <= '0;
                        end
                    end
                    DB_DN: begin
                        if (!pressed[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == DB_LAST) begin
                                state[i]  <= HELD;
                                cnt[i]    <= '0;
                                oLevel[i] <= 1'b1;
                                oPulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 10'd1;
                            end
                        end
                    end
                    HELD: begin
                        if (!pressed[i]) begin
                            state[i] <= DB_UP;
                            cnt[i]   <= '0;
                        end else if (!repeat_en[i]) begin
                            cnt[i] <= '0;
                        end else if (tick) begin
                            if (cnt[i] == DELAY_LAST) begin
                                state[i]  <= REPEAT;
                                cnt[i]    <= '0;
                                oPulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 10'd1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!pressed[i]) begin
                            state[i] <= DB_UP;
                            cnt[i]   <= '0;
                        end else if (!repeat_en[i]) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == RATE_LAST) begin
                                cnt[i]    <= '0;
                                oPulse[i] <= 1'b1;
                            end else begin
                                cnt[i] <= cnt[i] + 10'd1;
                            end
                        end
                    end
                    DB_UP: begin
                        // A bounce back to pressed restarts the repeat delay without a pulse.
                        if (pressed[i]) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else if (tick) begin
                            if (cnt[i] == DB_LAST) begin
                                state[i]  <= IDLE;
                                cnt[i]    <= '0;
                                oLevel[i] <= 1'b0;
                            end else begin
                                cnt[i] <= cnt[i] + 10'd1;
                            end
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed and random button traffic compared every cycle
// against a level/tick-count reference model, plus timing-window checks on pulses and levels.
`timescale 1ns/1ps
module tb_button_conditioner;

    localparam int N      = 3;
    localparam int T      = 4;
    localparam int DEB    = 3;
    localparam int RD     = 5;
    localparam int RR     = 2;
    localparam int LAT_LO = 2 + (DEB - 1) * T + 1;
    localparam int LAT_HI = 3 + DEB * T;
    localparam int REP_LO = 4 + (RD - 1) * T;
    localparam int REP_HI = 3 + RD * T;

    logic         Clock     = 1'b0;
    logic         Resetn    = 1'b1;
    logic [N-1:0] Buttons_n = '1;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] oLevel;
    logic [N-1:0] oPulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted level, ticks spent disagreeing with it, ticks spent held.
    int unsigned  m_edges;
    logic [N-1:0] m_raw1, m_raw2;
    logic [N-1:0] m_level, m_pulse;
    bit           m_pend [N];
    int           m_dcnt [N];
    int           m_rcnt [N];
    bit           m_rep  [N];

    button_conditioner #(
        .NUM_BTN(N), .TICK_CYCLES(T), .DEBOUNCE_MS(DEB),
        .REPEAT_DELAY_MS(RD), .REPEAT_RATE_MS(RR)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Buttons_n(Buttons_n),
        .repeat_en(repeat_en), .oLevel(oLevel), .oPulse(oPulse)
    );

    always #5 Clock = ~Clock;

    task automatic model_reset();
        m_edges = 0;
        m_raw1  = '1;
        m_raw2  = '1;
        m_level = '0;
        m_pulse = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_dcnt[i] = 0;
            m_rcnt[i] = 0;
            m_rep[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [N-1:0] p;
        bit           tick;
        p      = ~m_raw2;
        tick   = (m_edges % T) == T - 1;
        m_edges++;
        m_raw2 = m_raw1;
        m_raw1 = Buttons_n;
        for (int i = 0; i < N; i++) begin
            m_pulse[i] = 1'b0;
            if (p[i] == m_level[i]) begin
                if (m_pend[i]) begin
                    m_pend[i] = 1'b0;
                    m_dcnt[i] = 0;
                    m_rcnt[i] = 0;
                end else if (m_level[i]) begin
                    if (!repeat_en[i]) begin
                        m_rcnt[i] = 0;
                        m_rep[i]  = 1'b0;
                    end else if (tick) begin
                        m_rcnt[i]++;
                        if (m_rcnt[i] == (m_rep[i] ? RR : RD)) begin
                            m_pulse[i] = 1'b1;
                            m_rep[i]   = 1'b1;
                            m_rcnt[i]  = 0;
                        end
                    end
                end
            end else if (!m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_dcnt[i] = 0;
                m_rcnt[i] = 0;
                m_rep[i]  = 1'b0;
            end else if (tick) begin
                m_dcnt[i]++;
                if (m_dcnt[i] == DEB) begin
                    m_level[i] = p[i];
                    m_pulse[i] = p[i];
                    m_pend[i]  = 1'b0;
                    m_dcnt[i]  = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (oLevel !== '0 || oPulse !== '0) begin
            n_err++;
            $display("FAIL reset_async level=%b pulse=%b exp 000/000", oLevel, oPulse);
        end
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL reset_release c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] stim [$];
        int pulses = 0;
        int first  = -1;
        repeat_en = '0;
        idle($urandom_range(0, T - 1));
        repeat (100) stim.push_back(3'b110);
        repeat (40)  stim.push_back(3'b111);
        for (int c = 0; c < stim.size(); c++) begin
            Buttons_n = stim[c];
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL press_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (oPulse[0]) begin
                pulses++;
                if (first < 0) begin
                    first = c + 1;
                    n_vec++;
                    if (oLevel[0] !== 1'b1) begin
                        n_err++;
                        $display("FAIL press_level_edge level=%b exp 1", oLevel[0]);
                    end
                end
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL press_count got %0d exp 1", pulses);
        end
        n_vec++;
        if (first < LAT_LO || first > LAT_HI) begin
            n_err++;
            $display("FAIL press_latency got %0d exp %0d..%0d", first, LAT_LO, LAT_HI);
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] stim [$];
        int lens [3] = '{1, 3, 7};
        int seen = 0;
        repeat_en = '0;
        for (int j = 0; j < 3; j++) begin
            repeat (lens[j]) stim.push_back(3'b101);
            repeat (2)       stim.push_back(3'b111);
        end
        repeat (30) stim.push_back(3'b111);
        for (int c = 0; c < stim.size(); c++) begin
            Buttons_n = stim[c];
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL bounce_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (oLevel[1] || oPulse[1]) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL bounce_reject cycles_active=%0d exp 0", seen);
        end
    endtask

    task automatic test_auto_repeat();
        logic [N-1:0] stim [$];
        int times [$];
        int fall = -1;
        repeat_en = 3'b001;
        idle($urandom_range(0, T - 1));
        repeat (80) stim.push_back(3'b110);
        repeat (40) stim.push_back(3'b111);
        for (int c = 0; c < stim.size(); c++) begin
            Buttons_n = stim[c];
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL repeat_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (oPulse[0]) times.push_back(c);
            if (c >= 80 && fall < 0 && oLevel[0] === 1'b0) fall = c - 79;
        end
        n_vec++;
        if (times.size() < 4) begin
            n_err++;
            $display("FAIL repeat_count got %0d exp >=4", times.size());
        end
        for (int k = 1; k < times.size(); k++) begin
            n_vec++;
            if (times[k] - times[k-1] != ((k == 1) ? RD * T : RR * T)) begin
                n_err++;
                $display("FAIL repeat_gap k=%0d got %0d exp %0d", k, times[k] - times[k-1], (k == 1) ? RD * T : RR * T);
            end
        end
        n_vec++;
        if (fall < LAT_LO || fall > LAT_HI) begin
            n_err++;
            $display("FAIL release_latency got %0d exp %0d..%0d", fall, LAT_LO, LAT_HI);
        end
        repeat_en = '0;
    endtask

    task automatic test_release_bounce();
        logic [N-1:0] stim [$];
        int pre_pulses = 0;
        int post_first = -1;
        int drops = 0;
        repeat_en = '0;
        repeat (30) stim.push_back(3'b011);
        repeat (5)  stim.push_back(3'b111);
        repeat (40) stim.push_back(3'b011);
        repeat (40) stim.push_back(3'b111);
        for (int c = 0; c < stim.size(); c++) begin
            Buttons_n    = stim[c];
            repeat_en[2] = (c >= 30);
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL rbounce_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (c >= 20 && c < 75 && oLevel[2] !== 1'b1) drops++;
            if (oPulse[2] && c < 35) pre_pulses++;
            if (oPulse[2] && c >= 35 && post_first < 0) post_first = c - 34;
        end
        n_vec++;
        if (drops != 0) begin
            n_err++;
            $display("FAIL rbounce_level low_cycles=%0d exp 0", drops);
        end
        n_vec++;
        if (pre_pulses != 1) begin
            n_err++;
            $display("FAIL rbounce_extra_pulse got %0d exp 1", pre_pulses);
        end
        n_vec++;
        if (post_first < REP_LO || post_first > REP_HI) begin
            n_err++;
            $display("FAIL rbounce_repeat_delay got %0d exp %0d..%0d", post_first, REP_LO, REP_HI);
        end
        repeat_en = '0;
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] stim [$];
        logic [N-1:0] first = '0;
        int mid_pulses = 0;
        repeat_en = '0;
        idle($urandom_range(0, T - 1));
        repeat (40) stim.push_back(3'b010);
        repeat (30) stim.push_back(3'b111);
        for (int c = 0; c < stim.size(); c++) begin
            Buttons_n = stim[c];
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL simul_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (first == '0) first = oPulse;
            if (oPulse[1]) mid_pulses++;
        end
        n_vec++;
        if (first !== 3'b101) begin
            n_err++;
            $display("FAIL simul_edge got %b exp 101", first);
        end
        n_vec++;
        if (mid_pulses != 0) begin
            n_err++;
            $display("FAIL simul_idle_bit got %0d exp 0", mid_pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int first  = -1;
        repeat_en = 3'b001;
        Buttons_n = 3'b110;
        for (int c = 0; c < 60 && pulses < 2; c++) begin
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL rstmid_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (oPulse[0]) pulses++;
        end
        n_vec++;
        if (pulses != 2) begin
            n_err++;
            $display("FAIL rstmid_setup pulses=%0d exp 2", pulses);
        end
        idle(3);
        Resetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (oLevel !== m_level || oPulse !== m_pulse) begin
            n_err++;
            $display("FAIL rstmid_async level=%b pulse=%b exp %b/%b", oLevel, oPulse, m_level, m_pulse);
        end
        @(posedge Clock);
        #1 Resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL rstmid_after c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
            if (oPulse[0] && first < 0) first = c + 1;
        end
        n_vec++;
        if (first < LAT_LO || first > LAT_HI) begin
            n_err++;
            $display("FAIL rstmid_latency got %0d exp %0d..%0d", first, LAT_LO, LAT_HI);
        end
        Buttons_n = '1;
        repeat_en = '0;
        idle(30);
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    Buttons_n[i] = ~Buttons_n[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 90))
                                                          : int'($urandom_range(1, 14));
                end
                hold[i]--;
                if ($urandom_range(0, 99) == 0) repeat_en[i] = ~repeat_en[i];
            end
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL random_model c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
        end
        Buttons_n = '1;
        for (int c = 0; c < 40; c++) begin
            step();
            n_vec++;
            if (oLevel !== m_level || oPulse !== m_pulse) begin
                n_err++;
                $display("FAIL random_drain c=%0d level=%b pulse=%b exp %b/%b", c, oLevel, oPulse, m_level, m_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
